irq_stimulus_gen: RTL

- Parametrised, multi-channel interrupt stimulus source for the pipelined MIPS CPU system-level bench. Replaces the single hard-wired interrupt reg.
- Drives up to N_CH hardware interrupt lines into mips (HWInt).
- Each channel fires on a macroscopic-PC match or on a periodic cycle count.
- Each channel has level, pulse or periodic mode, and is cleared by a CPU store to the acknowledge address.

---
 rtl/irq_stim_pkg.sv | 18 +
 rtl/irq_stim_channel.sv | 121 ++++++++++++
 rtl/irq_stimulus_gen.sv | 64 ++++++
 3 files changed

// File: rtl/irq_stim_pkg.sv
// Shared encodings for the interrupt stimulus source: channel modes, channel FSM states
// and the default acknowledge address.
package irq_stim_pkg;

    localparam logic [1:0] MODE_OFF      = 2'd0;
    localparam logic [1:0] MODE_PC_LEVEL = 2'd1;
    localparam logic [1:0] MODE_PC_PULSE = 2'd2;
    localparam logic [1:0] MODE_PERIODIC = 2'd3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARMED  = 3'd1;
    localparam logic [2:0] ST_COUNT  = 3'd2;
    localparam logic [2:0] ST_ASSERT = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [31:0] DEFAULT_ACK_ADDR = 32'h0000_7F20;

endpackage

// File: rtl/irq_stim_channel.sv
// One interrupt channel: PC-match or periodic trigger, level/pulse/periodic hold, ack clear.
// irq is registered one cycle after the trigger condition; no backpressure.
module irq_stim_channel
    import irq_stim_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_mode,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic [ADDR_W-1:0] macro_pc,
    input  logic              macro_pc_valid,
    input  logic              ack,
    output logic              irq,
    output logic              irq_next,
    output logic              armed
);

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] trig_addr;
    logic [CNT_W-1:0]  reload;
    logic [CNT_W-1:0]  counter;
    logic [CNT_W-1:0]  counter_next;
    logic [CNT_W-1:0]  cfg_reload;
    logic              pc_match;

    // A period of 0 behaves like a period of 1.
    assign cfg_reload = (cfg_count == '0) ? '0 : cfg_count - CNT_W'(1);
    assign pc_match   = macro_pc_valid && (macro_pc == trig_addr);

    always_comb begin
        state_next   = state;
        counter_next = counter;
        irq_next     = irq;
        if (cfg_we) begin
            irq_next     = 1'b0;
            counter_next = '0;
            case (cfg_mode)
                MODE_PC_LEVEL, MODE_PC_PULSE: state_next = ST_ARMED;
                MODE_PERIODIC: begin
                    state_next   = ST_COUNT;
                    counter_next = cfg_reload;
                end
                default: state_next = ST_IDLE;
            endcase
        end else begin
            case (state)
                ST_ARMED: begin
                    if (pc_match) begin
                        state_next = ST_ASSERT;
                        irq_next   = 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (counter == '0) begin
                        state_next = ST_ASSERT;
                        irq_next   = 1'b1;
                    end else begin
                        counter_next = counter - CNT_W'(1);
                    end
                end
                ST_ASSERT: begin
                    // The counter stays frozen here, so late acks never stack up periods.
                    case (mode)
                        MODE_PC_PULSE: begin
                            state_next = ST_DONE;
                            irq_next   = 1'b0;
                        end
                        MODE_PC_LEVEL: begin
                            if (ack) begin
                                state_next = ST_DONE;
                                irq_next   = 1'b0;
                            end
                        end
                        MODE_PERIODIC: begin
                            if (ack) begin
                                state_next   = ST_COUNT;
                                counter_next = reload;
                                irq_next     = 1'b0;
                            end
                        end
                        default: begin
                            state_next = ST_IDLE;
                            irq_next   = 1'b0;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            mode      <= MODE_OFF;
            trig_addr <= '0;
            reload    <= '0;
            counter   <= '0;
            irq       <= 1'b0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
            irq     <= irq_next;
            if (cfg_we) begin
                mode      <= cfg_mode;
                trig_addr <= cfg_addr;
                reload    <= cfg_reload;
            end
        end
    end

    assign armed = (state == ST_ARMED) || (state == ST_COUNT);

endmodule

// File: rtl/irq_stimulus_gen.sv
// Multi-channel interrupt stimulus for the MIPS system bench; drives HWInt lines.
// All outputs registered, irq one cycle after trigger; no backpressure.
module irq_stimulus_gen
    import irq_stim_pkg::*;
#(
    parameter int                N_CH     = 6,
    parameter int                ADDR_W   = 32,
    parameter int                CNT_W    = 16,
    parameter logic [ADDR_W-1:0] ACK_ADDR = ADDR_W'(DEFAULT_ACK_ADDR),
    localparam int               CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic [ADDR_W-1:0] macro_pc,
    input  logic              macro_pc_valid,
    input  logic              ack_we,
    input  logic [ADDR_W-1:0] ack_addr,
    input  logic [N_CH-1:0]   ack_wdata,
    output logic [N_CH-1:0]   irq,
    output logic              irq_any,
    output logic [N_CH-1:0]   armed
);

    logic            ack_hit;
    logic [N_CH-1:0] irq_next;

    assign ack_hit = ack_we && (ack_addr == ACK_ADDR);

    // Out-of-range cfg_ch matches no channel, so the write is dropped.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        irq_stim_channel #(
            .ADDR_W (ADDR_W),
            .CNT_W  (CNT_W)
        ) u_ch (
            .clk            (clk),
            .reset          (reset),
            .cfg_we         (cfg_we && (cfg_ch == CH_W'(i))),
            .cfg_mode       (cfg_mode),
            .cfg_addr       (cfg_addr),
            .cfg_count      (cfg_count),
            .macro_pc       (macro_pc),
            .macro_pc_valid (macro_pc_valid),
            .ack            (ack_hit && ack_wdata[i]),
            .irq            (irq[i]),
            .irq_next       (irq_next[i]),
            .armed          (armed[i])
        );
    end

    // OR of the next-state vector keeps irq_any aligned with irq.
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_any <= 1'b0;
        end else begin
            irq_any <= |irq_next;
        end
    end

endmodule
